adc_driver: RTL and testbench

ADC_DRIVER -- requirements
Module: adc_driver

---
 rtl/adc_driver_pkg.sv | 27 ++
 rtl/adc_lut_search.sv | 54 +++++
 rtl/adc_driver.sv | 95 +++++++++
 tb/tb_adc_driver.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/adc_driver_pkg.sv
// adc_driver_pkg: shared constants and types for the ADC driver and its LUT search pipeline
package adc_driver_pkg;
  localparam int SAMPLE_W      = 16;
  localparam int LANES         = 8;
  localparam int LATENCY       = 10;
  localparam int SEARCH_STAGES = LATENCY - 2;
  localparam int REG_IDX       = 0;
  localparam int REG_THR_LO    = 1;
  localparam int REG_THR_HI    = 2;
  localparam int REG_OUT       = 3;
  localparam int REG_CTRL      = 4;
  localparam int REG_COUNT     = 5;

  typedef struct packed {
    logic                       v;
    logic [7:0]                 idx;
    logic signed [SAMPLE_W-1:0] peak;
  } stage_t;

  function automatic logic signed [SAMPLE_W-1:0] lane_max(input logic [LANES*SAMPLE_W-1:0] d);
    logic signed [SAMPLE_W-1:0] m;
    m = d[SAMPLE_W-1:0];
    for (int k = 1; k < LANES; k++)
      if ($signed(d[SAMPLE_W*k +: SAMPLE_W]) > m) m = d[SAMPLE_W*k +: SAMPLE_W];
    return m;
  endfunction
endpackage

// File: rtl/adc_lut_search.sv
// adc_lut_search: bit-serial binary search of the threshold LUT, one index bit per stage,
// followed by a registered lookup of the output byte.
module adc_lut_search
  import adc_driver_pkg::*;
#(
  parameter int LUT_SIZE = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid_i,
  input  logic signed [SAMPLE_W-1:0] peak_i,
  input  logic signed [SAMPLE_W-1:0] thr_i [LUT_SIZE],
  input  logic [7:0]                 out_i [LUT_SIZE],
  output logic [7:0]                 val_out_o,
  output logic                       val_valid_o
);
  localparam int IW = $clog2(LUT_SIZE);
  stage_t     st_q [SEARCH_STAGES];
  stage_t     st_d [SEARCH_STAGES];
  stage_t     prev;
  logic [7:0] cand;
  logic       take;
  logic [7:0] val_out_q;
  logic       val_valid_q;

  assign val_out_o   = val_out_q;
  assign val_valid_o = val_valid_q;

  // Candidates beyond a smaller LUT are simply never taken, keeping latency fixed.
  always_comb begin
    prev = '0;
    cand = '0;
    take = 1'b0;
    for (int s = 0; s < SEARCH_STAGES; s++) begin
      prev     = (s == 0) ? '{v: in_valid_i, idx: 8'd0, peak: peak_i} : st_q[s-1];
      cand     = prev.idx | (8'd1 << (SEARCH_STAGES - 1 - s));
      take     = ({24'd0, cand} < 32'(LUT_SIZE)) && (thr_i[cand[IW-1:0]] <= $signed(prev.peak));
      st_d[s]  = prev;
      st_d[s].idx = take ? cand : prev.idx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SEARCH_STAGES; s++) st_q[s] <= '0;
      val_out_q   <= '0;
      val_valid_q <= 1'b0;
    end else begin
      st_q        <= st_d;
      val_out_q   <= out_i[st_q[SEARCH_STAGES-1].idx[IW-1:0]];
      val_valid_q <= st_q[SEARCH_STAGES-1].v;
    end
  end
endmodule

// File: rtl/adc_driver.sv
// adc_driver: GPIO-programmed threshold LUT scaler for ADC beat peaks, with an optional
// single-register raw-sample DMA pass-through.
module adc_driver
  import adc_driver_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'd0,
  parameter int          LUT_SIZE  = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               gpio_in,
  input  logic [LANES*SAMPLE_W-1:0] s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  output logic [7:0]                val_out,
  output logic                      val_valid,
  input  logic                      adc_input_scaler_run,
  output logic [LANES*SAMPLE_W-1:0] m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready
);
  localparam int IW = $clog2(LUT_SIZE);
  logic [2:0]                 wsync_q;
  logic [16:0]                off;
  logic [REG_COUNT-1:0]       hit;
  logic [7:0]                 idx_q, lo_q, hi_q;
  logic                       dma_en_q, rdy_q, accept;
  logic signed [SAMPLE_W-1:0] thr_q [LUT_SIZE];
  logic [7:0]                 out_q [LUT_SIZE];
  logic signed [SAMPLE_W-1:0] peak_q, peak_d;
  logic                       pk_v_q, pk_v_d, m_v_q, m_v_d;
  logic [LANES*SAMPLE_W-1:0]  m_data_q, m_data_d;
  logic [6:0]                 unused_gpio;

  assign unused_gpio   = gpio_in[31:25];
  // Wide subtraction makes addresses below BASE_ADDR wrap far out of range.
  assign off           = {1'b0, gpio_in[15:0]} - {1'b0, BASE_ADDR};
  assign hit           = (wsync_q[1] && !wsync_q[2] && off < 17'(REG_COUNT)) ? (5'd1 << off[2:0]) : '0;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign s_axis_tready = rdy_q && (!dma_en_q || !m_v_q || m_axis_tready);
  assign m_axis_tvalid = m_v_q;
  assign m_axis_tdata  = m_data_q;

  always_comb begin
    peak_d   = lane_max(s_axis_tdata);
    pk_v_d   = accept && adc_input_scaler_run;
    m_v_d    = (accept && dma_en_q) ? 1'b1 : (m_axis_tready ? 1'b0 : m_v_q);
    m_data_d = (accept && dma_en_q) ? s_axis_tdata : m_data_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wsync_q  <= '0;
      idx_q    <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      dma_en_q <= 1'b0;
      rdy_q    <= 1'b0;
      for (int i = 0; i < LUT_SIZE; i++) begin
        thr_q[i] <= '0;
        out_q[i] <= '0;
      end
      peak_q   <= '0;
      pk_v_q   <= 1'b0;
      m_v_q    <= 1'b0;
      m_data_q <= '0;
    end else begin
      wsync_q  <= {wsync_q[1:0], gpio_in[24]};
      rdy_q    <= 1'b1;
      if (hit[REG_IDX]) idx_q <= gpio_in[23:16];
      if (hit[REG_THR_LO]) lo_q <= gpio_in[23:16];
      if (hit[REG_THR_HI]) hi_q <= gpio_in[23:16];
      if (hit[REG_CTRL]) dma_en_q <= gpio_in[16];
      if (hit[REG_OUT]) begin
        thr_q[idx_q[IW-1:0]] <= {hi_q, lo_q};
        out_q[idx_q[IW-1:0]] <= gpio_in[23:16];
      end
      peak_q   <= peak_d;
      pk_v_q   <= pk_v_d;
      m_v_q    <= m_v_d;
      m_data_q <= m_data_d;
    end
  end

  adc_lut_search #(.LUT_SIZE(LUT_SIZE)) u_search (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (pk_v_q),
    .peak_i     (peak_q),
    .thr_i      (thr_q),
    .out_i      (out_q),
    .val_out_o  (val_out),
    .val_valid_o(val_valid)
  );
endmodule

// File: tb/tb_adc_driver.sv
// tb_adc_driver: directed checks of LUT scaling, latency, run gating, DMA handshake and reset.
module tb_adc_driver;
  localparam logic [15:0] B = 16'h0040;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [31:0]  gpio_in = '0;
  logic [127:0] s_axis_tdata = '0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tready;
  logic [7:0]   val_out;
  logic         val_valid;
  logic         adc_input_scaler_run = 1'b0;
  logic [127:0] m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b1;
  int           n_chk = 0;
  int           n_err = 0;
  int           npulse;
  int           pcyc [8];
  logic [7:0]   pval [8];
  logic [15:0]  t;
  logic [127:0] vec [4];
  logic [7:0]   exp4 [4];

  always #5 clk = ~clk;

  adc_driver #(.BASE_ADDR(B), .LUT_SIZE(256)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .gpio_in             (gpio_in),
    .s_axis_tdata        (s_axis_tdata),
    .s_axis_tvalid       (s_axis_tvalid),
    .s_axis_tready       (s_axis_tready),
    .val_out             (val_out),
    .val_valid           (val_valid),
    .adc_input_scaler_run(adc_input_scaler_run),
    .m_axis_tdata        (m_axis_tdata),
    .m_axis_tvalid       (m_axis_tvalid),
    .m_axis_tready       (m_axis_tready)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mk(input int lane, input logic [15:0] v, input logic [15:0] fill);
    logic [127:0] d;
    for (int k = 0; k < 8; k++) d[16*k +: 16] = (k == lane) ? v : fill;
    return d;
  endfunction

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    gpio_in = {7'h55, 1'b0, d, a};
    @(negedge clk);
    gpio_in[24] = 1'b1;
    repeat (3) @(negedge clk);
    gpio_in[24] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic lookup(input string tag, input logic [127:0] data, input logic [7:0] exp);
    int lat;
    @(negedge clk);
    s_axis_tdata = data;
    s_axis_tvalid = 1'b1;
    adc_input_scaler_run = 1'b1;
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    adc_input_scaler_run = 1'b0;
    lat = 1;
    while (!val_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, lat, 10);
    chk({tag, "_val"}, val_out, exp);
  endtask

  task automatic watch(input int n);
    npulse = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (val_valid) begin
        if (npulse < 8) begin
          pcyc[npulse] = c;
          pval[npulse] = val_out;
        end
        npulse++;
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_vv", val_valid, 0);
    chk("rst_vo", val_out, 0);
    chk("rst_mv", m_axis_tvalid, 0);
    chk("rst_md", m_axis_tdata, 0);
    chk("rst_rdy", s_axis_tready, 0);
    rst = 1'b1;
    #1 chk("rdy_pre_clk", s_axis_tready, 0);
    @(negedge clk);
    chk("rdy_post_clk", s_axis_tready, 1);

    for (int i = 0; i < 256; i++) begin
      t = 16'((i - 128) * 256);
      wr(B + 16'd0, 8'(i));
      wr(B + 16'd1, t[7:0]);
      wr(B + 16'd2, t[15:8]);
      wr(B + 16'd3, 8'(i));
    end

    lookup("zero", mk(0, 16'h0000, 16'h8000), 8'd128);
    lookup("min", mk(0, 16'h8000, 16'h8000), 8'd0);
    lookup("max", mk(3, 16'h7FFF, 16'h8000), 8'd255);
    lookup("l5", mk(5, 16'h0100, 16'hFF00), 8'd129);
    lookup("neg1", mk(2, 16'hFFFF, 16'h8000), 8'd127);
    lookup("p255", mk(7, 16'h00FF, 16'hC000), 8'd128);

    wr(B + 16'd0, 8'd128);
    wr(16'h0003, 8'hAA);
    wr(B + 16'd5, 8'hAA);
    lookup("base", mk(0, 16'h0000, 16'h8000), 8'd128);

    vec[0] = mk(0, 16'h0000, 16'h8000); exp4[0] = 8'd128;
    vec[1] = mk(1, 16'h7FFF, 16'h8000); exp4[1] = 8'd255;
    vec[2] = mk(2, 16'h8000, 16'h8000); exp4[2] = 8'd0;
    vec[3] = mk(5, 16'h0100, 16'hFF00); exp4[3] = 8'd129;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      s_axis_tdata = vec[k];
      s_axis_tvalid = 1'b1;
      adc_input_scaler_run = 1'b1;
    end
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    adc_input_scaler_run = 1'b0;
    watch(20);
    chk("b2b_cnt", npulse, 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("b2b_val%0d", k), pval[k], exp4[k]);
      chk($sformatf("b2b_cyc%0d", k), pcyc[k] - pcyc[0], k);
    end

    @(negedge clk);
    s_axis_tdata = mk(3, 16'h7FFF, 16'h8000);
    s_axis_tvalid = 1'b1;
    adc_input_scaler_run = 1'b0;
    @(negedge clk);
    s_axis_tdata = mk(0, 16'h0000, 16'h8000);
    adc_input_scaler_run = 1'b1;
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    adc_input_scaler_run = 1'b0;
    watch(20);
    chk("run_cnt", npulse, 1);
    chk("run_val", pval[0], 8'd128);

    wr(B + 16'd4, 8'd1);
    m_axis_tready = 1'b0;
    @(negedge clk);
    chk("dma_rdy_idle", s_axis_tready, 1);
    s_axis_tdata = {4{32'h1111_2222}};
    s_axis_tvalid = 1'b1;
    @(negedge clk);
    s_axis_tdata = {4{32'h3333_4444}};
    chk("dma_mv", m_axis_tvalid, 1);
    chk("dma_md", m_axis_tdata, {4{32'h1111_2222}});
    chk("dma_rdy_full", s_axis_tready, 0);
    repeat (2) @(negedge clk);
    chk("dma_hold", m_axis_tdata, {4{32'h1111_2222}});
    m_axis_tready = 1'b1;
    #1 chk("dma_rdy_back", s_axis_tready, 1);
    chk("dma_same", m_axis_tdata, {4{32'h1111_2222}});
    @(negedge clk);
    chk("dma_next", m_axis_tdata, {4{32'h3333_4444}});
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    chk("dma_drain", m_axis_tvalid, 0);
    chk("dma_rdy_empty", s_axis_tready, 1);

    m_axis_tready = 1'b0;
    @(negedge clk);
    s_axis_tdata = {4{32'h5555_6666}};
    s_axis_tvalid = 1'b1;
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    wr(B + 16'd4, 8'd0);
    chk("off_keep_v", m_axis_tvalid, 1);
    chk("off_keep_d", m_axis_tdata, {4{32'h5555_6666}});
    chk("off_rdy", s_axis_tready, 1);
    m_axis_tready = 1'b1;
    @(negedge clk);
    chk("off_drain", m_axis_tvalid, 0);
    s_axis_tdata = {4{32'h7777_8888}};
    s_axis_tvalid = 1'b1;
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    chk("off_no_fwd", m_axis_tvalid, 0);

    wr(B + 16'd4, 8'd1);
    m_axis_tready = 1'b0;
    @(negedge clk);
    s_axis_tdata = mk(3, 16'h7FFF, 16'h8000);
    s_axis_tvalid = 1'b1;
    adc_input_scaler_run = 1'b1;
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    adc_input_scaler_run = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_vv", val_valid, 0);
    chk("mid_rdy", s_axis_tready, 0);
    chk("mid_mv", m_axis_tvalid, 0);
    chk("mid_md", m_axis_tdata, 0);
    @(negedge clk);
    rst = 1'b1;
    m_axis_tready = 1'b1;
    watch(15);
    chk("mid_no_pulse", npulse, 0);
    lookup("clr_max", mk(3, 16'h7FFF, 16'h8000), 8'd0);
    lookup("clr_zero", mk(0, 16'h0000, 16'h8000), 8'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
